// File: rtl/ps2_keycode_rx.sv
// ---------------------------------------------------------------------------
// ps2_keycode_rx
//
// PS/2 keyboard receiver. The block deglitches the PS/2 clock and deserialises
// 11-bit frames (start, 8 data bits LSB first, odd parity, stop). It decodes
// the E0/F0/E1 prefixes into make/break events that carry an extended-key
// flag. Events are queued in a first-word-fall-through FIFO with a
// valid/ready handshake.
//
// Parameters
//   FILTER_LEN   consecutive disagreeing samples needed to flip the filtered
//                PS/2 clock (2..15)
//   TIMEOUT_CYC  clk cycles without a falling edge before a partial frame
//                is aborted
//   FIFO_DEPTH   event entries, power of 2, >= 2
//
// Ports
//   clk, rst_n   system clock; asynchronous active-low reset
//   ps2_clk      PS/2 clock from the connector (asynchronous)
//   ps2_data     PS/2 data from the connector (asynchronous)
//   ev_valid     FIFO head holds an event
//   ev_ready     consumer accepts the head event
//   ev_code      scan code at the FIFO head (0 when empty)
//   ev_ext       head event was preceded by E0
//   ev_brk       head event is a key release (preceded by F0)
//   frame_err    1-cycle pulse on a parity error, stop-bit error or timeout
//   overflow     sticky, an event was dropped because the FIFO was full
//   err_clr      synchronous clear of overflow
//   fifo_count   number of stored events
// ---------------------------------------------------------------------------
module ps2_keycode_rx #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_brk,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frameState_e;

  // -------------------------------------------------------------------------
  // Synchronisers. Both lines reset to the bus idle level (high) so that
  // leaving reset cannot look like a falling clock edge or a start bit.
  // -------------------------------------------------------------------------
  logic [1:0] clkSync_q;
  logic [1:0] dataSync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk};
      dataSync_q <= {dataSync_q[0], ps2_data};
    end
  end

  logic dataBit;
  assign dataBit = dataSync_q[1];

  // -------------------------------------------------------------------------
  // Clock filter and falling-edge strobe. Any sample that agrees with the
  // filtered level restarts the run counter, so pulses shorter than
  // FILTER_LEN samples never reach the frame logic.
  // -------------------------------------------------------------------------
  logic [3:0] filtCnt_q, filtCnt_d;
  logic       filtClk_q, filtClk_d;
  logic       strobe_q, strobe_d;

  always_comb begin
    filtCnt_d = 4'd0;
    filtClk_d = filtClk_q;
    strobe_d  = 1'b0;
    if (clkSync_q[1] != filtClk_q) begin
      if (filtCnt_q == 4'(FILTER_LEN - 1)) begin
        filtClk_d = clkSync_q[1];
        // The current level is 1, so this flip is a falling edge.
        strobe_d  = filtClk_q;
      end else begin
        filtCnt_d = filtCnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filtCnt_q <= 4'd0;
      filtClk_q <= 1'b1;
      strobe_q  <= 1'b0;
    end else begin
      filtCnt_q <= filtCnt_d;
      filtClk_q <= filtClk_d;
      strobe_q  <= strobe_d;
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM: next state, shift register and timeout.
  // -------------------------------------------------------------------------
  frameState_e   state_q, state_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmoCnt_q, tmoCnt_d;
  logic          frameErr_q, frameErr_d;
  logic          good_q, good_d;

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tmoCnt_d   = '0;
    frameErr_d = 1'b0;
    good_d     = 1'b0;

    if (state_q != IDLE) begin
      tmoCnt_d = strobe_q ? '0 : tmoCnt_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        // A start bit of 1 is line noise; it is ignored and raises no error.
        if (strobe_q && !dataBit) begin
          state_d  = DATA;
          bitCnt_d = 3'd0;
        end
      end
      DATA: begin
        if (strobe_q) begin
          shift_d  = {dataBit, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (strobe_q) begin
          parity_d = dataBit;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (strobe_q) begin
          state_d = IDLE;
          if (((^shift_q) ^ parity_q) && dataBit) begin
            good_d = 1'b1;
          end else begin
            frameErr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && !strobe_q && (tmoCnt_q == TW'(TIMEOUT_CYC - 1))) begin
      state_d    = IDLE;
      tmoCnt_d   = '0;
      frameErr_d = 1'b1;
    end
  end

  // Frame FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitCnt_q   <= 3'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      tmoCnt_q   <= '0;
      frameErr_q <= 1'b0;
      good_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmoCnt_q   <= tmoCnt_d;
      frameErr_q <= frameErr_d;
      good_q     <= good_d;
    end
  end

  assign frame_err = frameErr_q;

  // -------------------------------------------------------------------------
  // Prefix decoder. It runs one cycle after a good stop bit. shift_q still
  // holds the byte because the next frame cannot reach DATA that soon. The
  // Pause sequence begins with E1, and that E1 plus the next 7 bytes are
  // swallowed.
  // -------------------------------------------------------------------------
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [2:0] skip_q, skip_d;
  logic       push;

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;
    push   = 1'b0;
    if (frameErr_q) begin
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = 3'd0;
    end else if (good_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else begin
        case (shift_q)
          8'hE0:   ext_d  = 1'b1;
          8'hF0:   brk_d  = 1'b1;
          8'hE1:   skip_d = 3'd7;
          default: begin
            push  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        endcase
      end
    end
  end

  // Decoder registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      skip_q <= 3'd0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      skip_q <= skip_d;
    end
  end

  // -------------------------------------------------------------------------
  // Event FIFO, first-word-fall-through. A push into a full FIFO still
  // succeeds when the head is popped in the same cycle.
  // -------------------------------------------------------------------------
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, popEn, doPush, drop;
  logic [9:0]    head;

  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign popEn  = (count_q != '0) && ev_ready;
  assign doPush = push && (!full || popEn);
  assign drop   = push && full && !popEn;

  always_comb begin
    count_d = count_q;
    case ({doPush, popEn})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as err_clr wins so that the loss is not hidden.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Storage array; it needs no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= {ext_q, brk_q, shift_q};
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (popEn)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign head       = mem_q[rdPtr_q];
  assign ev_valid   = (count_q != '0);
  assign ev_code    = ev_valid ? head[7:0] : 8'h00;
  assign ev_brk     = ev_valid ? head[8]   : 1'b0;
  assign ev_ext     = ev_valid ? head[9]   : 1'b0;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_keycode_rx
//
// Directed bench for ps2_keycode_rx. A bit-banged PS/2 host model drives
// frames, and a monitor logs every popped event and every frame_err cycle.
// Each scenario task compares the log and the DUT outputs against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_ps2_keycode_rx;

  localparam int FL    = 4;
  localparam int TMO   = 2000;
  localparam int DEPTH = 8;
  localparam int H     = 20;

  logic       clk;
  logic       rst_n;
  logic       ps2Clk;
  logic       ps2Data;
  logic       evValid;
  logic       evReady;
  logic [7:0] evCode;
  logic       evExt;
  logic       evBrk;
  logic       frameErr;
  logic       overflowO;
  logic       errClr;
  logic [3:0] fifoCount;

  int checks = 0;
  int errors = 0;

  logic [9:0] evQ [$];
  int         errCycles = 0;
  int         errPulses = 0;
  logic       prevErr = 1'b0;

  ps2_keycode_rx #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TMO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2Clk),
    .ps2_data  (ps2Data),
    .ev_valid  (evValid),
    .ev_ready  (evReady),
    .ev_code   (evCode),
    .ev_ext    (evExt),
    .ev_brk    (evBrk),
    .frame_err (frameErr),
    .overflow  (overflowO),
    .err_clr   (errClr),
    .fifo_count(fifoCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The monitor samples on the falling edge. An accepted head is popped at
  // the next rising edge, so each event is logged exactly once.
  always @(negedge clk) begin
    if (evValid && evReady) evQ.push_back({evExt, evBrk, evCode});
    if (frameErr) errCycles <= errCycles + 1;
    if (frameErr && !prevErr) errPulses <= errPulses + 1;
    prevErr <= frameErr;
  end

  // Sends the first nBits bits of a frame. An optional short low glitch is
  // placed in the high phase of bit 4.
  task automatic sendFrame(input logic [7:0] code, input bit flipPar,
                           input bit stopBit, input int nBits, input bit glitch);
    logic [10:0] bits;
    bits = {stopBit, (~^code) ^ flipPar, code, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      @(negedge clk);
      ps2Data = bits[i];
      repeat (H / 2) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2Clk = 1'b1;
      if (glitch && i == 4) begin
        repeat (H / 2) @(negedge clk);
        ps2Clk = 1'b0;
        repeat (FL - 1) @(negedge clk);
        ps2Clk = 1'b1;
        repeat (H) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    ps2Data = 1'b1;
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ps2Clk = 1'b1; ps2Data = 1'b1; evReady = 1'b1; errClr = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({evValid, evCode, evExt, evBrk, frameErr, overflowO, fifoCount} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {evValid, evCode, evExt, evBrk, frameErr, overflowO, fifoCount});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({evValid, frameErr, fifoCount} !== 6'h0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got %h expected 0", {evValid, frameErr, fifoCount});
    end
  endtask

  task automatic test_single();
    int base, eBase;
    logic [9:0] got;
    base = evQ.size(); eBase = errCycles;
    sendFrame(8'h1C, 0, 1, 11, 0);
    settle();
    got = (evQ.size() > base) ? evQ[base] : 10'h3FF;
    checks++;
    if (evQ.size() !== base + 1) begin
      errors++;
      $display("[TB] FAIL single_count: got %0d expected %0d", evQ.size() - base, 1);
    end
    checks++;
    if (got !== {2'b00, 8'h1C}) begin
      errors++;
      $display("[TB] FAIL single_event: got %h expected %h", got, {2'b00, 8'h1C});
    end
    checks++;
    if (fifoCount !== 4'd0) begin
      errors++;
      $display("[TB] FAIL single_fifo_count: got %0d expected 0", fifoCount);
    end
    checks++;
    if (errCycles !== eBase) begin
      errors++;
      $display("[TB] FAIL single_no_err: got %0d expected 0", errCycles - eBase);
    end
  endtask

  task automatic test_prefix();
    int base;
    logic [9:0] got;
    base = evQ.size();
    sendFrame(8'hE0, 0, 1, 11, 0);
    sendFrame(8'hF0, 0, 1, 11, 0);
    settle();
    checks++;
    if (evQ.size() !== base) begin
      errors++;
      $display("[TB] FAIL prefix_no_event: got %0d expected 0", evQ.size() - base);
    end
    sendFrame(8'h75, 0, 1, 11, 0);
    settle();
    got = (evQ.size() > base) ? evQ[base] : 10'h3FF;
    checks++;
    if (evQ.size() !== base + 1 || got !== {2'b11, 8'h75}) begin
      errors++;
      $display("[TB] FAIL prefix_ext_brk: got %h (n=%0d) expected %h (n=1)",
               got, evQ.size() - base, {2'b11, 8'h75});
    end
    sendFrame(8'h1C, 0, 1, 11, 0);
    settle();
    got = (evQ.size() > base + 1) ? evQ[base + 1] : 10'h3FF;
    checks++;
    if (evQ.size() !== base + 2 || got !== {2'b00, 8'h1C}) begin
      errors++;
      $display("[TB] FAIL prefix_cleared: got %h (n=%0d) expected %h (n=2)",
               got, evQ.size() - base, {2'b00, 8'h1C});
    end
  endtask

  task automatic test_bad_frame();
    int base, eBase, pBase;
    logic [9:0] got;
    for (int mode = 0; mode < 2; mode++) begin
      base = evQ.size(); eBase = errCycles; pBase = errPulses;
      sendFrame(8'hE0, 0, 1, 11, 0);
      if (mode == 0) sendFrame(8'h1C, 1, 1, 11, 0);
      else           sendFrame(8'h1C, 0, 0, 11, 0);
      sendFrame(8'h1D, 0, 1, 11, 0);
      settle();
      checks++;
      if (errPulses - pBase !== 1 || errCycles - eBase !== 1) begin
        errors++;
        $display("[TB] FAIL bad_frame_err%0d: got pulses %0d cycles %0d expected 1 1",
                 mode, errPulses - pBase, errCycles - eBase);
      end
      got = (evQ.size() > base) ? evQ[base] : 10'h3FF;
      checks++;
      if (evQ.size() !== base + 1 || got !== {2'b00, 8'h1D}) begin
        errors++;
        $display("[TB] FAIL bad_frame_event%0d: got %h (n=%0d) expected %h (n=1)",
                 mode, got, evQ.size() - base, {2'b00, 8'h1D});
      end
    end
  endtask

  task automatic test_timeout();
    int base, pBase;
    logic [9:0] got;
    base = evQ.size(); pBase = errPulses;
    sendFrame(8'h2D, 0, 1, 5, 0);
    repeat (TMO + 10) @(negedge clk);
    checks++;
    if (errPulses - pBase !== 1) begin
      errors++;
      $display("[TB] FAIL timeout_err: got %0d pulses expected 1", errPulses - pBase);
    end
    checks++;
    if (evQ.size() !== base) begin
      errors++;
      $display("[TB] FAIL timeout_no_event: got %0d expected 0", evQ.size() - base);
    end
    sendFrame(8'h2D, 0, 1, 11, 0);
    settle();
    got = (evQ.size() > base) ? evQ[base] : 10'h3FF;
    checks++;
    if (evQ.size() !== base + 1 || got !== {2'b00, 8'h2D}) begin
      errors++;
      $display("[TB] FAIL timeout_recover: got %h (n=%0d) expected %h (n=1)",
               got, evQ.size() - base, {2'b00, 8'h2D});
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [9];
    int base;
    logic [9:0] got;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
    base = evQ.size();
    for (int i = 0; i < 9; i++) sendFrame(seq[i], 0, 1, 11, 0);
    settle();
    got = (evQ.size() > base) ? evQ[base] : 10'h3FF;
    checks++;
    if (evQ.size() !== base + 1 || got !== {2'b00, 8'h1C}) begin
      errors++;
      $display("[TB] FAIL pause_skip: got %h (n=%0d) expected %h (n=1)",
               got, evQ.size() - base, {2'b00, 8'h1C});
    end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [9];
    int base;
    logic [9:0] got;
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    evReady = 1'b0;
    base = evQ.size();
    for (int i = 0; i < 9; i++) sendFrame(codes[i], 0, 1, 11, 0);
    settle();
    checks++;
    if (fifoCount !== 4'(DEPTH) || overflowO !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_full: got count %0d ovf %b expected %0d 1",
               fifoCount, overflowO, DEPTH);
    end
    checks++;
    if (evValid !== 1'b1 || evCode !== 8'h16) begin
      errors++;
      $display("[TB] FAIL ovf_head_hold: got valid %b code %h expected 1 16", evValid, evCode);
    end
    evReady = 1'b1;
    repeat (DEPTH + 4) @(negedge clk);
    checks++;
    if (evQ.size() !== base + DEPTH) begin
      errors++;
      $display("[TB] FAIL ovf_drain_count: got %0d expected %0d", evQ.size() - base, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      got = (evQ.size() > base + i) ? evQ[base + i] : 10'h3FF;
      checks++;
      if (got !== {2'b00, codes[i]}) begin
        errors++;
        $display("[TB] FAIL ovf_order%0d: got %h expected %h", i, got, {2'b00, codes[i]});
      end
    end
    checks++;
    if ({evValid, evCode, fifoCount} !== 13'h0 || overflowO !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_empty_sticky: got valid %b code %h count %0d ovf %b expected 0 00 0 1",
               evValid, evCode, fifoCount, overflowO);
    end
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    @(negedge clk);
    checks++;
    if (overflowO !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_clear: got %b expected 0", overflowO);
    end
  endtask

  task automatic test_glitch();
    int base, eBase;
    logic [9:0] got;
    base = evQ.size(); eBase = errCycles;
    sendFrame(8'h3A, 0, 1, 11, 1);
    settle();
    got = (evQ.size() > base) ? evQ[base] : 10'h3FF;
    checks++;
    if (evQ.size() !== base + 1 || got !== {2'b00, 8'h3A} || errCycles !== eBase) begin
      errors++;
      $display("[TB] FAIL glitch_filter: got %h (n=%0d err=%0d) expected %h (n=1 err=0)",
               got, evQ.size() - base, errCycles - eBase, {2'b00, 8'h3A});
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    logic [9:0] got;
    evReady = 1'b0;
    sendFrame(8'h22, 0, 1, 11, 0);
    settle();
    checks++;
    if (evValid !== 1'b1 || evCode !== 8'h22) begin
      errors++;
      $display("[TB] FAIL rstmid_pre: got valid %b code %h expected 1 22", evValid, evCode);
    end
    sendFrame(8'h33, 0, 1, 4, 0);
    ps2Clk = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({evValid, evCode, evExt, evBrk, frameErr, overflowO, fifoCount} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL rstmid_outputs: got %h expected 0",
               {evValid, evCode, evExt, evBrk, frameErr, overflowO, fifoCount});
    end
    ps2Clk = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    evReady = 1'b1;
    repeat (10) @(negedge clk);
    base = evQ.size();
    sendFrame(8'h15, 0, 1, 11, 0);
    settle();
    got = (evQ.size() > base) ? evQ[base] : 10'h3FF;
    checks++;
    if (evQ.size() !== base + 1 || got !== {2'b00, 8'h15}) begin
      errors++;
      $display("[TB] FAIL rstmid_recover: got %h (n=%0d) expected %h (n=1)",
               got, evQ.size() - base, {2'b00, 8'h15});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_bad_frame();
    test_timeout();
    test_pause();
    test_overflow();
    test_glitch();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
